// File: rtl/wave_seq_pkg.sv
// Shared definitions for the wave sequencer: generator wave codes, per-wave
// period lengths and the controller state encoding.
package wave_seq_pkg;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'd0,
    WAVE_SAW    = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_OFF    = 2'd3
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int PER_W = 6;
  localparam logic [PER_W-1:0] PER_SQUARE = 6'd32;
  localparam logic [PER_W-1:0] PER_SAW    = 6'd16;
  localparam logic [PER_W-1:0] PER_TRI    = 6'd32;
  localparam logic [PER_W-1:0] PER_OFF    = 6'd32;

  function automatic logic [PER_W-1:0] period_of(wave_t w);
    period_of = PER_OFF;
    case (w)
      WAVE_SQUARE: period_of = PER_SQUARE;
      WAVE_SAW:    period_of = PER_SAW;
      WAVE_TRI:    period_of = PER_TRI;
      WAVE_OFF:    period_of = PER_OFF;
    endcase
  endfunction

endpackage

// File: rtl/wave_seq_table.sv
// Four-entry program table: one synchronous write port, combinational read
// by entry index.
module wave_seq_table
  import wave_seq_pkg::*;
#(
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       waddr,
  input  logic [REP_W+2:0] wdata,
  input  logic [1:0]       raddr,
  output logic             rd_last,
  output wave_t            rd_wave,
  output logic [REP_W-1:0] rd_rep
);

  logic [3:0]       last_q;
  wave_t            wave_q [4];
  logic [REP_W-1:0] rep_q  [4];

  // NOTE: this storage is reset on purpose -- a freshly reset sequencer must
  // see a well-defined silent program that terminates at entry 3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 4'b1000;
      for (int i = 0; i < 4; i++) begin
        wave_q[i] <= WAVE_OFF;
        rep_q[i]  <= '0;
      end
    end else if (we) begin
      last_q[waddr] <= wdata[REP_W+2];
      wave_q[waddr] <= wave_t'(wdata[REP_W+1:REP_W]);
      rep_q[waddr]  <= wdata[REP_W-1:0];
    end
  end

  assign rd_last = last_q[raddr];
  assign rd_wave = wave_q[raddr];
  assign rd_rep  = rep_q[raddr];

endmodule

// File: rtl/wave_sequencer.sv
// Steps a waveform generator through a four-entry program of (wave, repeat)
// entries, clearing the generator phase at the start of each entry.
module wave_sequencer
  import wave_seq_pkg::*;
#(
  parameter int REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [REP_W+2:0] cfg_wdata,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic [1:0]       wave_choise,
  output logic             gen_rst_n,
  output logic             busy,
  output logic [1:0]       entry_idx,
  output logic             done
);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             pend_q, pend_d;
  logic             ran_q, ran_d;
  wave_t            wave_q, wave_d;
  logic             grst_q, grst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             rd_last;
  wave_t            rd_wave;
  logic [REP_W-1:0] rd_rep;
  logic             stop_seen, do_advance, do_halt;

  wave_seq_table #(.REP_W(REP_W)) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_we && (state_q == ST_IDLE)),
    .waddr   (cfg_addr),
    .wdata   (cfg_wdata),
    .raddr   (idx_q),
    .rd_last (rd_last),
    .rd_wave (rd_wave),
    .rd_rep  (rd_rep)
  );

  assign stop_seen = pend_q | stop;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    per_d      = per_q;
    rep_d      = rep_q;
    ran_d      = ran_q;
    wave_d     = wave_q;
    grst_d     = 1'b1;
    done_d     = 1'b0;
    pend_d     = pend_q | (stop & (state_q != ST_IDLE));
    do_advance = 1'b0;
    do_halt    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wave_d = WAVE_OFF;
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          ran_d   = 1'b0;
          pend_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (stop_seen) begin
          do_halt = 1'b1;
        end else if (rd_rep == '0) begin
          do_advance = 1'b1;
        end else begin
          state_d = ST_RUN;
          wave_d  = rd_wave;
          grst_d  = 1'b0;
          per_d   = period_of(rd_wave);
          rep_d   = rd_rep;
          ran_d   = 1'b1;
        end
      end
      ST_RUN: begin
        // per_q reaches zero on the last cycle of each period.
        if (per_q != '0) begin
          per_d = per_q - PER_W'(1);
        end else if (stop_seen) begin
          do_halt = 1'b1;
        end else if (rep_q == REP_W'(1)) begin
          do_advance = 1'b1;
        end else begin
          rep_d = rep_q - REP_W'(1);
          per_d = period_of(wave_q) - PER_W'(1);
        end
      end
      default: do_halt = 1'b1;
    endcase

    // A wrap only happens if this pass ran at least one entry; an all-zero
    // program with loop set would otherwise spin forever.
    if (do_advance) begin
      if (!(rd_last || idx_q == 2'd3)) begin
        state_d = ST_LOAD;
        idx_d   = idx_q + 2'd1;
      end else if (loop && ran_q) begin
        state_d = ST_LOAD;
        idx_d   = '0;
        ran_d   = 1'b0;
      end else begin
        do_halt = 1'b1;
      end
    end

    if (do_halt) begin
      state_d = ST_IDLE;
      wave_d  = WAVE_OFF;
      done_d  = 1'b1;
      pend_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      per_q   <= '0;
      rep_q   <= '0;
      pend_q  <= 1'b0;
      ran_q   <= 1'b0;
      wave_q  <= WAVE_OFF;
      grst_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      rep_q   <= rep_d;
      pend_q  <= pend_d;
      ran_q   <= ran_d;
      wave_q  <= wave_d;
      grst_q  <= grst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign wave_choise = wave_q;
  assign gen_rst_n   = grst_q;
  assign busy        = busy_q;
  assign entry_idx   = idx_q;
  assign done        = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed and randomized programs
// compared cycle by cycle against a trace-level reference model.
module tb_wave_sequencer;

  localparam int REP_W = 8;
  localparam int NO_STOP = 1000000;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [REP_W+2:0] cfg_wdata;
  logic             start, stop, loop;
  logic [1:0]       wave_choise;
  logic             gen_rst_n, busy, done;
  logic [1:0]       entry_idx;

  int vectors = 0;
  int errors  = 0;

  bit m_last [4];
  int m_wave [4];
  int m_rep  [4];

  typedef struct {
    logic [1:0] wave;
    logic       grst;
    logic       busy;
    logic [1:0] idx;
    bit         chk_idx;
    logic       done;
  } exp_t;

  exp_t exp_q [$];

  wave_sequencer #(.REP_W(REP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .wave_choise (wave_choise),
    .gen_rst_n   (gen_rst_n),
    .busy        (busy),
    .entry_idx   (entry_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic int period(input int w);
    return (w == 1) ? 16 : 32;
  endfunction

  function automatic void model_reset_table();
    for (int i = 0; i < 4; i++) begin
      m_last[i] = (i == 3);
      m_wave[i] = 3;
      m_rep[i]  = 0;
    end
  endfunction

  function automatic void push(input int w, input bit g, input bit b, input int i, input bit d);
    exp_t e;
    e.wave    = 2'(w);
    e.grst    = g;
    e.busy    = b;
    e.idx     = 2'(i);
    e.chk_idx = (i >= 0);
    e.done    = d;
    exp_q.push_back(e);
  endfunction

  // Outputs per cycle, cycle 0 being the first cycle after start is sampled.
  // A stop seen in cycle stop_at is honoured in any LOAD cycle or at the last
  // cycle of a period, whichever comes first at or after stop_at.
  function automatic void build_expected(input bit lp, input int stop_at);
    int c = 0, i = 0, cur = 3, p = 0, total = 0;
    bit ran = 0, halt = 0, fin = 0;
    exp_q.delete();
    while (!halt && !fin && c < 4000) begin
      push(cur, 1, 1, i, 0);
      if (c >= stop_at) halt = 1;
      c++;
      if (!halt && m_rep[i] > 0) begin
        p     = period(m_wave[i]);
        total = m_rep[i] * p;
        ran   = 1;
        cur   = m_wave[i];
        for (int k = 0; k <= total && !halt; k++) begin
          push(cur, k != 0, 1, i, 0);
          if (k > 0 && k % p == 0 && c >= stop_at) halt = 1;
          c++;
        end
      end
      if (!halt) begin
        if (!(m_last[i] || i == 3)) i++;
        else if (lp && ran) begin i = 0; ran = 0; end
        else fin = 1;
      end
    end
    push(3, 1, 0, -1, 1);
    push(3, 1, 0, -1, 0);
  endfunction

  task automatic write_entry(input int a, input bit l, input int w, input int r);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(a);
    cfg_wdata = {l, 2'(w), REP_W'(r)};
    m_last[a] = l;
    m_wave[a] = w;
    m_rep[a]  = r;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_seq(input string name, input bit lp, input int stop_at, input bit garbage,
                         input bit stop_with_start, input bit wr0, input logic [REP_W+2:0] wr0_data);
    exp_t e;
    if (wr0) begin
      m_last[0] = wr0_data[REP_W+2];
      m_wave[0] = int'(wr0_data[REP_W+1:REP_W]);
      m_rep[0]  = int'(wr0_data[REP_W-1:0]);
    end
    build_expected(lp, stop_at);
    @(negedge clk);
    loop  = lp;
    start = 1'b1;
    stop  = stop_with_start;
    if (wr0) begin
      cfg_we    = 1'b1;
      cfg_addr  = 2'd0;
      cfg_wdata = wr0_data;
    end
    @(negedge clk);
    for (int c = 0; c < exp_q.size(); c++) begin
      e = exp_q[c];
      vectors++;
      if (wave_choise !== e.wave || gen_rst_n !== e.grst || busy !== e.busy || done !== e.done ||
          (e.chk_idx && entry_idx !== e.idx)) begin
        errors++;
        $display("FAIL %s cyc %0d: got wave=%0d grst=%b busy=%b idx=%0d done=%b, want wave=%0d grst=%b busy=%b idx=%0d done=%b",
                 name, c, wave_choise, gen_rst_n, busy, entry_idx, done,
                 e.wave, e.grst, e.busy, e.idx, e.done);
      end
      start  = 1'b0;
      stop   = (c == stop_at);
      cfg_we = 1'b0;
      if (garbage && e.busy) begin
        start     = 1'($urandom_range(0, 1));
        cfg_we    = 1'b1;
        cfg_addr  = 2'($urandom);
        cfg_wdata = (REP_W+3)'($urandom);
      end
      @(negedge clk);
    end
    start  = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (wave_choise !== 2'd3 || gen_rst_n !== 1'b0 || busy !== 1'b0 || entry_idx !== 2'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got wave=%0d grst=%b busy=%b idx=%0d done=%b, want 3 0 0 0 0",
               wave_choise, gen_rst_n, busy, entry_idx, done);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (wave_choise !== 2'd3 || gen_rst_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got wave=%0d grst=%b busy=%b done=%b, want 3 1 0 0",
               wave_choise, gen_rst_n, busy, done);
    end
  endtask

  task automatic test_reset_table_loop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_stop: got busy=%b done=%b, want 0 0", busy, done);
    end
    run_seq("zero_loop", 1'b1, NO_STOP, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_single_saw();
    write_entry(0, 1'b1, 1, 2);
    run_seq("single_saw", 1'b0, NO_STOP, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_skip();
    write_entry(0, 1'b0, 0, 1);
    write_entry(1, 1'b0, 2, 0);
    write_entry(2, 1'b1, 2, 1);
    run_seq("skip", 1'b0, NO_STOP, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_stop_loop();
    write_entry(0, 1'b1, 1, 1);
    run_seq("stop_loop", 1'b1, 6, 1'b0, 1'b0, 1'b0, '0);
    run_seq("stop_in_load", 1'b1, 0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_start_stop_together();
    write_entry(0, 1'b1, 0, 1);
    run_seq("start_and_stop", 1'b0, NO_STOP, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic test_write_with_start();
    write_entry(0, 1'b1, 0, 1);
    run_seq("write_with_start", 1'b0, NO_STOP, 1'b0, 1'b0, 1'b1, {1'b1, 2'd1, REP_W'(1)});
  endtask

  task automatic test_cfg_busy();
    write_entry(0, 1'b0, 1, 1);
    write_entry(1, 1'b0, 2, 0);
    write_entry(2, 1'b0, 0, 1);
    write_entry(3, 1'b0, 3, 1);
    run_seq("cfg_busy_a", 1'b0, NO_STOP, 1'b1, 1'b0, 1'b0, '0);
    run_seq("cfg_busy_b", 1'b0, NO_STOP, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    bit saw_done = 0;
    write_entry(0, 1'b1, 1, 2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (wave_choise !== 2'd3 || busy !== 1'b0 || gen_rst_n !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got wave=%0d busy=%b grst=%b done=%b, want 3 0 0 0",
               wave_choise, busy, gen_rst_n, done);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset_table();
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin
      errors++;
      $display("FAIL post_reset_quiet: got done/busy activity=1, want 0");
    end
    run_seq("post_reset_table", 1'b0, NO_STOP, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    bit lp;
    int sa;
    for (int n = 0; n < 12; n++) begin
      for (int a = 0; a < 4; a++)
        write_entry(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      lp = 1'($urandom_range(0, 1));
      if (lp || $urandom_range(0, 1) == 1) sa = int'($urandom_range(0, 150));
      else sa = NO_STOP;
      run_seq("random", lp, sa, 1'b1, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    start     = 1'b0;
    stop      = 1'b0;
    loop      = 1'b0;
    model_reset_table();
    repeat (3) @(negedge clk);
    test_reset();
    test_reset_table_loop();
    test_single_saw();
    test_skip();
    test_stop_loop();
    test_start_stop_together();
    test_write_with_start();
    test_cfg_busy();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
